// File: rtl/hc05_rx_if.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | hc05_rx_if : serial input and message read port of hc05_rx       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface hc05_rx_if;
    logic       rx;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       frame_err;
    logic       msg_ready;
    logic [4:0] msg_len;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       msg_ack;
    logic       msg_ovf;
    logic       msg_drop;

    modport slave (
        input  rx, rd_addr, msg_ack,
        output byte_data, byte_valid, frame_err, msg_ready, msg_len,
               rd_data, msg_ovf, msg_drop
    );

    modport master (
        output rx, rd_addr, msg_ack,
        input  byte_data, byte_valid, frame_err, msg_ready, msg_len,
               rd_data, msg_ovf, msg_drop
    );
endinterface
`default_nettype wire

// File: rtl/hc05_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | hc05_rx : 8N1 UART receiver + '#'-terminated message assembler   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module hc05_rx #(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] TERM         = 8'h23
) (
    input wire        clk,
    input wire        jreset_n,
    hc05_rx_if.slave  bus
);

    localparam int             CW        = $clog2(CLKS_PER_BIT + 1);
    localparam int             AW        = $clog2(MAX_LEN);
    localparam logic [CW-1:0]  c_half    = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0]  c_bit     = CW'(CLKS_PER_BIT);
    localparam logic [4:0]     c_last    = 5'(MAX_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    state_t        r_state;
    logic          r_sync1;
    logic          r_rx_s;
    logic          r_rx_prev;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_stop_ok;
    logic          r_stop_bad;
    logic [7:0]    r_byte_data;
    logic          r_byte_valid;
    logic          r_frame_err;

    logic          r_msg_ready;
    logic [4:0]    r_msg_len;
    logic [4:0]    r_wr_ptr;
    logic          r_msg_ovf;
    logic          r_msg_drop;
    logic [7:0]    r_buf [MAX_LEN];

    logic          w_ack;
    logic [4:0]    w_ptr;
    logic          w_store;

    always_ff @(posedge clk or negedge jreset_n) begin
        if (!jreset_n) begin
            r_sync1   <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= bus.rx;
            r_rx_s    <= r_sync1;
            r_rx_prev <= r_rx_s;
        end
    end

    // r_cnt reads as the number of cycles since rx_s fell (or since the last sample)
    always_ff @(posedge clk or negedge jreset_n) begin
        if (!jreset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'h00;
            r_stop_ok    <= 1'b0;
            r_stop_bad   <= 1'b0;
            r_byte_data  <= 8'h00;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_stop_ok    <= 1'b0;
            r_stop_bad   <= 1'b0;
            r_byte_valid <= r_stop_ok;
            r_frame_err  <= r_stop_bad;
            if (r_stop_ok) begin
                r_byte_data <= r_shift;
            end
            case (r_state)
                S_IDLE: begin
                    if (r_rx_prev && !r_rx_s) begin
                        r_cnt   <= CW'(2);
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt == c_half) begin
                        if (r_rx_s) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt     <= CW'(1);
                            r_bit_idx <= 3'd0;
                            r_state   <= S_DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (r_cnt == c_bit) begin
                        r_cnt   <= CW'(1);
                        r_shift <= {r_rx_s, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (r_cnt == c_bit) begin
                        if (r_rx_s) begin
                            r_stop_ok <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_stop_bad <= 1'b1;
                            r_state    <= S_WAIT_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // An ack in the same cycle as a byte is applied first, so the byte sees an empty buffer
    assign w_ack   = bus.msg_ack & r_msg_ready;
    assign w_ptr   = w_ack ? 5'd0 : r_wr_ptr;
    assign w_store = r_byte_valid & (~r_msg_ready | w_ack) & (r_byte_data != TERM);

    always_ff @(posedge clk or negedge jreset_n) begin
        if (!jreset_n) begin
            r_msg_ready <= 1'b0;
            r_msg_len   <= 5'd0;
            r_wr_ptr    <= 5'd0;
            r_msg_ovf   <= 1'b0;
            r_msg_drop  <= 1'b0;
        end else begin
            r_msg_ovf <= 1'b0;
            if (w_ack) begin
                r_msg_ready <= 1'b0;
                r_wr_ptr    <= 5'd0;
                r_msg_drop  <= 1'b0;
            end
            if (r_byte_valid) begin
                if (r_msg_ready && !w_ack) begin
                    r_msg_drop <= 1'b1;
                end else if (r_byte_data == TERM) begin
                    if (w_ptr != 5'd0) begin
                        r_msg_len   <= w_ptr;
                        r_msg_ready <= 1'b1;
                    end
                end else if (w_ptr == c_last) begin
                    r_msg_ovf <= 1'b1;
                    r_wr_ptr  <= 5'd0;
                end else begin
                    r_wr_ptr <= w_ptr + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge jreset_n) begin
        if (!jreset_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_buf[i] <= 8'h00;
            end
        end else if (w_store) begin
            r_buf[w_ptr[AW-1:0]] <= r_byte_data;
        end
    end

    assign bus.byte_data  = r_byte_data;
    assign bus.byte_valid = r_byte_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.msg_ready  = r_msg_ready;
    assign bus.msg_len    = r_msg_len;
    assign bus.msg_ovf    = r_msg_ovf;
    assign bus.msg_drop   = r_msg_drop;
    assign bus.rd_data    = r_buf[bus.rd_addr[AW-1:0]];

endmodule
`default_nettype wire

// File: tb/tb_hc05_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | tb_hc05_rx : directed bench; full-rate instance for bit timing,  |
// | short-bit instance for message behaviour.  Rev 1.0               |
// +------------------------------------------------------------------+
module tb_hc05_rx;

    localparam int C_SLOW = 434;
    localparam int C_FAST = 20;

    logic clk      = 1'b0;
    logic jreset_n = 1'b0;
    always #5 clk = ~clk;

    hc05_rx_if bus_s ();
    hc05_rx_if bus   ();

    hc05_rx #(.CLKS_PER_BIT(C_SLOW), .MAX_LEN(16), .TERM(8'h23)) dut_slow (
        .clk      (clk),
        .jreset_n (jreset_n),
        .bus      (bus_s)
    );

    hc05_rx #(.CLKS_PER_BIT(C_FAST), .MAX_LEN(16), .TERM(8'h23)) dut (
        .clk      (clk),
        .jreset_n (jreset_n),
        .bus      (bus)
    );

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         exp_nv;
        int         exp_nf;
        logic [7:0] exp_byte;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int nv_s = 0, nf_s = 0, no_s = 0;
    int nv = 0, nf = 0, no = 0;
    logic [7:0] last_byte = 8'h00;

    always @(negedge clk) begin
        if (bus_s.byte_valid) nv_s++;
        if (bus_s.frame_err)  nf_s++;
        if (bus_s.msg_ovf)    no_s++;
        if (bus.byte_valid) begin
            nv++;
            last_byte = bus.byte_data;
        end
        if (bus.frame_err) nf++;
        if (bus.msg_ovf)   no++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic stop_bit);
        @(posedge clk); #1 bus.rx = 1'b0;
        for (int i = 0; i < 9; i++) begin
            repeat (C_FAST) @(posedge clk);
            #1 bus.rx = (i < 8) ? d[i] : stop_bit;
        end
        repeat (C_FAST) @(posedge clk);
        #1 bus.rx = 1'b1;
        repeat (C_FAST) @(posedge clk);
    endtask

    task automatic read_chk(input string name, input logic [3:0] a, input logic [7:0] e);
        bus.rd_addr = a;
        #1;
        chk(name, {24'h0, bus.rd_data}, {24'h0, e});
    endtask

    task automatic do_ack();
        @(posedge clk); #1 bus.msg_ack = 1'b1;
        @(posedge clk); #1 bus.msg_ack = 1'b0;
        chk("ack clears ready", {31'h0, bus.msg_ready}, 32'd0);
    endtask

    vec_t       vecs [5];
    logic [7:0] slow_d;
    int         lat;
    int         nv0, nf0, no0;
    int         got;
    string      msg;

    initial begin
        vecs[0] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[1] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vecs[2] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
        vecs[3] = '{8'h3C, 1'b0, 0, 1, 8'h00};
        vecs[4] = '{8'h81, 1'b1, 1, 0, 8'h81};

        bus.rx = 1'b1;   bus.rd_addr = 4'd0;   bus.msg_ack = 1'b0;
        bus_s.rx = 1'b1; bus_s.rd_addr = 4'd0; bus_s.msg_ack = 1'b0;

        #22;
        chk("reset outputs fast", {6'h0, bus.byte_data, bus.byte_valid, bus.frame_err, bus.msg_ready,
            bus.msg_len, bus.msg_ovf, bus.msg_drop, bus.rd_data}, 32'd0);
        chk("reset outputs slow", {6'h0, bus_s.byte_data, bus_s.byte_valid, bus_s.frame_err, bus_s.msg_ready,
            bus_s.msg_len, bus_s.msg_ovf, bus_s.msg_drop, bus_s.rd_data}, 32'd0);
        @(posedge clk); #1 jreset_n = 1'b1;

        repeat (10000) @(posedge clk);
        #1;
        chk("idle no pulses", nv_s + nf_s + no_s + nv + nf + no, 32'd0);
        chk("idle outputs slow", {16'h0, bus_s.byte_data, bus_s.msg_ready, bus_s.msg_len, bus_s.msg_drop}, 32'd0);

        // full-rate 0x55: byte_valid expected 4126 cycles after the raw falling edge
        slow_d = 8'h55;
        @(posedge clk); #1 bus_s.rx = 1'b0;
        fork
            begin
                for (int i = 0; i < 9; i++) begin
                    repeat (C_SLOW) @(posedge clk);
                    #1 bus_s.rx = (i < 8) ? slow_d[i] : 1'b1;
                end
            end
        join_none
        lat = 0;
        for (int n = 1; n <= 5000; n++) begin
            @(posedge clk); #1;
            if (bus_s.byte_valid) begin
                lat = n;
                break;
            end
        end
        chk("byte_valid latency", lat, 32'd4126);
        chk("byte 0x55", {24'h0, bus_s.byte_data}, 32'h55);
        @(posedge clk); #1;
        chk("byte_valid one cycle", {31'h0, bus_s.byte_valid}, 32'd0);
        repeat (C_SLOW) @(posedge clk);

        for (int i = 0; i < 5; i++) begin
            nv0 = nv; nf0 = nf;
            send(vecs[i].data, vecs[i].stop_bit);
            chk($sformatf("vec%0d valid", i), nv - nv0, vecs[i].exp_nv);
            chk($sformatf("vec%0d frame_err", i), nf - nf0, vecs[i].exp_nf);
            if (vecs[i].exp_nv != 0)
                chk($sformatf("vec%0d byte", i), {24'h0, last_byte}, {24'h0, vecs[i].exp_byte});
        end

        nv0 = nv; nf0 = nf;
        @(posedge clk); #1 bus.rx = 1'b0;
        repeat (6) @(posedge clk);
        #1 bus.rx = 1'b1;
        repeat (3 * C_FAST) @(posedge clk);
        chk("glitch no output", (nv - nv0) + (nf - nf0), 32'd0);

        send(8'h23, 1'b1);
        chk("table msg ready", {31'h0, bus.msg_ready}, 32'd1);
        chk("table msg len", {27'h0, bus.msg_len}, 32'd4);
        read_chk("table rd0", 4'd0, 8'h00);
        read_chk("table rd1", 4'd1, 8'hFF);
        read_chk("table rd2", 4'd2, 8'hA5);
        read_chk("table rd3", 4'd3, 8'h81);
        do_ack();

        msg = "FIM-ESU3-";
        for (int i = 0; i < msg.len(); i++) send(msg[i], 1'b1);
        chk("fim not ready before term", {31'h0, bus.msg_ready}, 32'd0);
        send(8'h23, 1'b1);
        chk("fim msg ready", {31'h0, bus.msg_ready}, 32'd1);
        chk("fim msg len", {27'h0, bus.msg_len}, 32'd9);
        for (int i = 0; i < msg.len(); i++) read_chk($sformatf("fim rd%0d", i), 4'(i), msg[i]);
        do_ack();

        no0 = no;
        for (int i = 0; i < 17; i++) begin
            send(8'h61 + 8'(i), 1'b1);
            if (i == 14) chk("no ovf at 15", no - no0, 32'd0);
            if (i == 15) chk("ovf at 16", no - no0, 32'd1);
        end
        chk("single ovf after 17", no - no0, 32'd1);
        send(8'h23, 1'b1);
        chk("ovf msg ready", {31'h0, bus.msg_ready}, 32'd1);
        chk("ovf msg len", {27'h0, bus.msg_len}, 32'd1);
        read_chk("ovf rd0", 4'd0, 8'h71);

        send(8'h41, 1'b1);
        chk("drop set", {31'h0, bus.msg_drop}, 32'd1);
        chk("drop keeps ready", {31'h0, bus.msg_ready}, 32'd1);
        read_chk("drop buf unchanged", 4'd0, 8'h71);

        got = 0;
        fork
            send(8'h42, 1'b1);
            begin
                for (int n = 0; n < 400; n++) begin
                    @(posedge clk); #1;
                    if (bus.byte_valid) begin
                        bus.msg_ack = 1'b1;
                        got = 1;
                        break;
                    end
                end
                @(posedge clk); #1 bus.msg_ack = 1'b0;
            end
        join
        chk("ack aligned with byte", got, 32'd1);
        chk("ack clears drop", {31'h0, bus.msg_drop}, 32'd0);
        chk("ack+byte ready low", {31'h0, bus.msg_ready}, 32'd0);
        read_chk("ack+byte rd0", 4'd0, 8'h42);
        send(8'h23, 1'b1);
        chk("ack+byte len", {27'h0, bus.msg_len}, 32'd1);
        chk("ack+byte ready", {31'h0, bus.msg_ready}, 32'd1);

        bus.rd_addr = 4'd0;
        fork
            send(8'hC3, 1'b1);
            begin
                repeat (90) @(posedge clk);
                #2 jreset_n = 1'b0;
                #1;
                chk("mid-frame reset outputs", {6'h0, bus.byte_data, bus.byte_valid, bus.frame_err, bus.msg_ready,
                    bus.msg_len, bus.msg_ovf, bus.msg_drop, bus.rd_data}, 32'd0);
            end
        join
        @(posedge clk); #1 jreset_n = 1'b1;
        repeat (4) @(posedge clk);
        nv0 = nv;
        send(8'h5A, 1'b1);
        chk("post-reset byte count", nv - nv0, 32'd1);
        chk("post-reset byte", {24'h0, last_byte}, 32'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
